// File: rtl/fp_nr_pkg.sv
// Shared types, constants and special-operand classification for the
// Newton-Raphson reciprocal / divide unit.
package fp_nr_pkg;

  typedef enum logic [2:0] {
    IDLE, SEED, MUL1, SUB, MUL2, FINAL, DONE
  } nr_state_t;

  localparam logic [31:0] FP_TWO     = 32'h40000000;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [31:0] FP_POS_INF = 32'h7F800000;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
  } special_t;

  function automatic logic [31:0] flush_denormal(input logic [31:0] v);
    return (v[30:23] == 8'h00) ? {v[31], 31'h0} : v;
  endfunction

  // Operands whose quotient is NaN, inf or zero bypass the iteration
  function automatic special_t is_special(input logic [31:0] a_in,
                                          input logic [31:0] b_in,
                                          input logic        divide);
    logic [31:0] a, b;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
    special_t    r;
    a      = flush_denormal(a_in);
    b      = flush_denormal(b_in);
    a_zero = (a[30:0] == 31'h0);
    b_zero = (b[30:0] == 31'h0);
    a_inf  = (a[30:0] == FP_POS_INF[30:0]);
    b_inf  = (b[30:0] == FP_POS_INF[30:0]);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    sgn    = divide ? (a[31] ^ b[31]) : b[31];
    r.valid  = 1'b1;
    r.result = FP_QNAN;
    if (b_nan || (divide && a_nan))
      r.result = FP_QNAN;
    else if (b_zero)
      r.result = (divide && a_zero) ? FP_QNAN : {sgn, FP_POS_INF[30:0]};
    else if (b_inf)
      r.result = (divide && a_inf) ? FP_QNAN : {sgn, 31'h0};
    else if (divide && a_zero)
      r.result = {sgn, 31'h0};
    else
      r.valid = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/fp_reciprocal_iterative_if.sv
// Start/done handshake and operand/result bus of the reciprocal unit.
interface fp_reciprocal_iterative_if;
  logic        start;
  logic        divide;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        busy;
  logic        done;
  logic [31:0] solution;

  modport master (output start, divide, operand_1, operand_2,
                  input  busy, done, solution);
  modport slave  (input  start, divide, operand_1, operand_2,
                  output busy, done, solution);
endinterface

// File: rtl/Alu_addAndSubtract.sv
// Single-precision add/subtract: denormals flushed, round-to-nearest-even.
module Alu_addAndSubtract (
  input  logic        subtract,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  output logic [31:0] result
);
  import fp_nr_pkg::*;

  function automatic logic [24:0] round_rne(input logic [23:0] m, input logic g, input logic s);
    return {1'b0, m} + 25'(g & (s | m[0]));
  endfunction

  logic [31:0]       op_b, op_hi, op_lo;
  logic [7:0]        diff;
  logic [26:0]       m_hi, m_lo;
  logic [27:0]       sum;
  logic              zero_sum;
  logic [4:0]        lz;
  logic signed [9:0] exp_r;
  logic [24:0]       rnd;
  logic [22:0]       frac;

  // Align the smaller magnitude with guard/round/sticky, add, renormalise, round
  always_comb begin
    op_b = {operand_2[31] ^ subtract, operand_2[30:0]};
    if (operand_1[30:0] >= op_b[30:0]) begin
      op_hi = operand_1;
      op_lo = op_b;
    end else begin
      op_hi = op_b;
      op_lo = operand_1;
    end
    diff = op_hi[30:23] - op_lo[30:23];
    m_hi = {1'b1, op_hi[22:0], 3'b000};
    m_lo = {1'b1, op_lo[22:0], 3'b000};
    if (diff > 8'd26)
      m_lo = 27'd1;
    else
      m_lo = (m_lo >> diff) | 27'(|(m_lo & ~(27'h7FFFFFF << diff)));
    if (op_hi[31] == op_lo[31])
      sum = {1'b0, m_hi} + {1'b0, m_lo};
    else
      sum = {1'b0, m_hi} - {1'b0, m_lo};
    zero_sum = (sum == 28'h0);
    exp_r    = $signed({2'b00, op_hi[30:23]});
    if (sum[27]) begin
      sum   = {1'b0, sum[27:2], sum[1] | sum[0]};
      exp_r = exp_r + 10'sd1;
    end
    lz = 5'd0;
    for (int i = 0; i < 27; i++)
      if (sum[i]) lz = 5'(26 - i);
    sum   = sum << lz;
    exp_r = exp_r - $signed({5'b0, lz});
    rnd   = round_rne(sum[26:3], sum[2], |sum[1:0]);
    frac  = rnd[24] ? rnd[23:1] : rnd[22:0];
    exp_r = exp_r + $signed({9'b0, rnd[24]});
    if (op_hi[30:23] == 8'hFF)
      result = (op_hi[22:0] != 23'h0 || (op_lo[30:0] == FP_POS_INF[30:0] && op_hi[31] != op_lo[31]))
               ? FP_QNAN : op_hi;
    else if (op_hi[30:23] == 8'h00)
      result = {op_hi[31] & op_lo[31], 31'h0};
    else if (op_lo[30:23] == 8'h00)
      result = op_hi;
    else if (zero_sum || exp_r <= 10'sd0)
      result = {zero_sum ? 1'b0 : op_hi[31], 31'h0};
    else if (exp_r >= 10'sd255)
      result = {op_hi[31], FP_POS_INF[30:0]};
    else
      result = {op_hi[31], exp_r[7:0], frac};
  end
endmodule

// File: rtl/Alu_multiplication.sv
// Single-precision multiply: denormals flushed, round-to-nearest-even.
module Alu_multiplication (
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  output logic [31:0] result
);
  import fp_nr_pkg::*;

  function automatic logic [24:0] round_rne(input logic [23:0] m, input logic g, input logic s);
    return {1'b0, m} + 25'(g & (s | m[0]));
  endfunction

  logic              sgn, grd, stk;
  logic [7:0]        ea, eb;
  logic [47:0]       prod;
  logic signed [9:0] exp_r;
  logic [23:0]       mant;
  logic [24:0]       rnd;
  logic [22:0]       frac;

  // Normalise the 48-bit significand product, round, then apply IEEE specials
  always_comb begin
    ea    = operand_1[30:23];
    eb    = operand_2[30:23];
    sgn   = operand_1[31] ^ operand_2[31];
    prod  = 48'({1'b1, operand_1[22:0]}) * 48'({1'b1, operand_2[22:0]});
    exp_r = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (prod[47]) begin
      mant  = prod[47:24];
      grd   = prod[23];
      stk   = |prod[22:0];
      exp_r = exp_r + 10'sd1;
    end else begin
      mant  = prod[46:23];
      grd   = prod[22];
      stk   = |prod[21:0];
    end
    rnd   = round_rne(mant, grd, stk);
    frac  = rnd[24] ? rnd[23:1] : rnd[22:0];
    exp_r = exp_r + $signed({9'b0, rnd[24]});
    if ((ea == 8'hFF && operand_1[22:0] != 23'h0) || (eb == 8'hFF && operand_2[22:0] != 23'h0))
      result = FP_QNAN;
    else if (ea == 8'hFF || eb == 8'hFF)
      result = (ea == 8'h00 || eb == 8'h00) ? FP_QNAN : {sgn, FP_POS_INF[30:0]};
    else if (ea == 8'h00 || eb == 8'h00)
      result = {sgn, 31'h0};
    else if (exp_r >= 10'sd255)
      result = {sgn, FP_POS_INF[30:0]};
    else if (exp_r <= 10'sd0)
      result = {sgn, 31'h0};
    else
      result = {sgn, exp_r[7:0], frac};
  end
endmodule

// File: rtl/fp_nr_seed.sv
// Initial estimate and special-case detection, kept out of the FSM.
module fp_nr_seed #(
  parameter logic [31:0] SEED_MAGIC = 32'h7EF311C3
) (
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  input  logic        divide,
  output logic [31:0] seed,
  output logic        special,
  output logic [31:0] special_result
);
  import fp_nr_pkg::*;

  logic [31:0] b_flush;
  special_t    chk;

  // Integer-subtract seed keeps the sign of b; denormal b is treated as zero
  always_comb begin
    b_flush        = flush_denormal(operand_2);
    chk            = is_special(operand_1, operand_2, divide);
    seed           = {b_flush[31], SEED_MAGIC[30:0] - b_flush[30:0]};
    special        = chk.valid;
    special_result = chk.result;
  end
endmodule

// File: rtl/fp_reciprocal_iterative.sv
// Sequential single-precision reciprocal/divide: seed, then ITERATIONS
// Newton-Raphson steps x <- x*(2 - b*x) on one shared multiplier and adder,
// with an optional a*x multiply for division.
module fp_reciprocal_iterative
  import fp_nr_pkg::*;
#(
  parameter int unsigned ITERATIONS = 3,
  parameter logic [31:0] SEED_MAGIC = 32'h7EF311C3
) (
  input logic                      clk,
  input logic                      rst_n,
  fp_reciprocal_iterative_if.slave bus
);

  nr_state_t   state, state_nxt;
  logic        accept, last_iter, div_q, special;
  logic [31:0] a_q, b_q, x, t, solution_q;
  logic [31:0] mul_a, mul_b, mul_y, add_y, seed, special_result;
  logic [2:0]  iter;

  assign last_iter    = (iter == 3'(ITERATIONS - 1));
  assign bus.solution = solution_q;

  fp_nr_seed #(.SEED_MAGIC(SEED_MAGIC)) u_seed (
    .operand_1(a_q), .operand_2(b_q), .divide(div_q),
    .seed(seed), .special(special), .special_result(special_result)
  );

  Alu_multiplication u_mul (.operand_1(mul_a), .operand_2(mul_b), .result(mul_y));

  // 2 - t is done as an add of 2.0 and t with its sign flipped
  Alu_addAndSubtract u_add (
    .subtract(1'b0), .operand_1(FP_TWO), .operand_2({~t[31], t[30:0]}), .result(add_y)
  );

  // Multiplier operand selection: b*x, x*t, or a*x for the final divide step
  always_comb begin
    mul_a = b_q;
    mul_b = x;
    case (state)
      MUL2:    begin mul_a = x;   mul_b = t; end
      FINAL:   begin mul_a = a_q; mul_b = x; end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs; DONE can accept a new request directly
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    bus.busy  = (state != IDLE) && (state != DONE);
    bus.done  = (state == DONE);
    case (state)
      IDLE:    begin accept = bus.start; if (bus.start) state_nxt = SEED; end
      SEED:    state_nxt = special ? DONE : MUL1;
      MUL1:    state_nxt = SUB;
      SUB:     state_nxt = MUL2;
      MUL2:    state_nxt = !last_iter ? MUL1 : (div_q ? FINAL : DONE);
      FINAL:   state_nxt = DONE;
      DONE:    begin accept = bus.start; state_nxt = bus.start ? SEED : IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on the accepting edge; the bus is free afterwards
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= bus.operand_1;
      b_q   <= bus.operand_2;
      div_q <= bus.divide;
    end
  end

  // Iteration registers; solution is written on the edge entering DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x          <= '0;
      t          <= '0;
      iter       <= '0;
      solution_q <= '0;
    end else begin
      case (state)
        SEED: begin
          if (special) solution_q <= special_result;
          else begin
            x    <= seed;
            iter <= '0;
          end
        end
        MUL1: t <= mul_y;
        SUB:  t <= add_y;
        MUL2: begin
          x <= mul_y;
          if (!last_iter)  iter <= iter + 3'd1;
          else if (!div_q) solution_q <= mul_y;
        end
        FINAL: begin
          x          <= mul_y;
          solution_q <= mul_y;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_reciprocal_iterative.sv
// Directed-vector bench for fp_reciprocal_iterative with ITERATIONS = 3, 1 and 7.
module tb_fp_reciprocal_iterative;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        divide = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fp_reciprocal_iterative_if bus3 ();
  fp_reciprocal_iterative_if bus1 ();
  fp_reciprocal_iterative_if bus7 ();

  assign bus3.start = start;  assign bus3.divide = divide;
  assign bus3.operand_1 = op1; assign bus3.operand_2 = op2;
  assign bus1.start = start;  assign bus1.divide = divide;
  assign bus1.operand_1 = op1; assign bus1.operand_2 = op2;
  assign bus7.start = start;  assign bus7.divide = divide;
  assign bus7.operand_1 = op1; assign bus7.operand_2 = op2;

  fp_reciprocal_iterative #(.ITERATIONS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  fp_reciprocal_iterative #(.ITERATIONS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  fp_reciprocal_iterative #(.ITERATIONS(7)) dut7 (.clk(clk), .rst_n(rst_n), .bus(bus7));

  // index 0: ITERATIONS=3, 1: ITERATIONS=1, 2: ITERATIONS=7
  logic [2:0]  done_v, busy_v;
  logic [31:0] sol_v [3];
  assign done_v   = {bus7.done, bus1.done, bus3.done};
  assign busy_v   = {bus7.busy, bus1.busy, bus3.busy};
  assign sol_v[0] = bus3.solution;
  assign sol_v[1] = bus1.solution;
  assign sol_v[2] = bus7.solution;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want,
                       input logic [31:0] tol);
    logic [31:0] d;
    checks++;
    d = (got >= want) ? got - want : want - got;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (tol %0d)", tag, got, want, tol);
    end
  endtask

  // Launch one operation (edge 0 = the edge sampling start) and watch for done
  task automatic run_op(input int sel, input logic div, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output int busy_bad);
    lat = -1; res = '0; busy_bad = 0;
    repeat (25) @(posedge clk);
    @(negedge clk);
    start = 1'b1; divide = div; op1 = a; op2 = b;
    @(posedge clk); #1;
    start = 1'b0; divide = ~div; op1 = 32'hDEADBEEF; op2 = 32'h3F800000;
    if (!busy_v[sel]) busy_bad++;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (done_v[sel]) begin
        lat = k;
        res = sol_v[sel];
        if (busy_v[sel]) busy_bad++;
      end else if (!busy_v[sel]) busy_bad++;
    end
  endtask

  task automatic do_vec(input string name, input int sel, input logic div,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] want,
                        input int want_lat, input logic [31:0] tol);
    int          lat, bb;
    logic [31:0] res;
    run_op(sel, div, a, b, lat, res, bb);
    check({name, "_lat"}, lat, want_lat, 0);
    check({name, "_res"}, res, want, tol);
    check({name, "_busy"}, bb, 0, 0);
  endtask

  initial begin
    int n_done, first_e, second_e;
    repeat (3) @(posedge clk); #1;
    check("rst_busy", 32'(bus3.busy), 0, 0);
    check("rst_done", 32'(bus3.done), 0, 0);
    check("rst_solution", bus3.solution, 32'h0, 0);
    rst_n = 1'b1;

    do_vec("recip_2",    0, 1'b0, 32'h0, 32'h40000000, 32'h3F000000, 10, 2);
    do_vec("recip_m4",   0, 1'b0, 32'h0, 32'hC0800000, 32'hBE800000, 10, 2);
    do_vec("div_6_3",    0, 1'b1, 32'h40C00000, 32'h40400000, 32'h40000000, 11, 2);
    do_vec("sp_pzero",   0, 1'b0, 32'h0, 32'h00000000, 32'h7F800000, 1, 0);
    do_vec("sp_nzero",   0, 1'b0, 32'h0, 32'h80000000, 32'hFF800000, 1, 0);
    do_vec("sp_nan",     0, 1'b0, 32'h0, 32'h7FC00001, 32'h7FC00000, 1, 0);
    do_vec("sp_inf",     0, 1'b0, 32'h0, 32'h7F800000, 32'h00000000, 1, 0);
    do_vec("sp_0div0",   0, 1'b1, 32'h0, 32'h00000000, 32'h7FC00000, 1, 0);

    // start held for 15 edges: accepted on edge 0 and on edge 11 (leaving DONE)
    repeat (25) @(posedge clk);
    @(negedge clk); start = 1'b1; divide = 1'b0; op2 = 32'h40000000;
    n_done = 0; first_e = -1; second_e = -1;
    for (int k = 0; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 14) start = 1'b0;
      if (bus3.done) begin
        n_done++;
        if (first_e < 0) first_e = k; else second_e = k;
      end
    end
    check("b2b_count", n_done, 2, 0);
    check("b2b_first", first_e, 10, 0);
    check("b2b_second", second_e, 21, 0);

    // start pulse while busy is ignored
    repeat (25) @(posedge clk);
    @(negedge clk); start = 1'b1; divide = 1'b0; op2 = 32'h40800000;
    n_done = 0; first_e = -1;
    for (int k = 0; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 0 || k == 4) start = 1'b0;
      if (k == 3) start = 1'b1;
      if (bus3.done) begin
        n_done++;
        if (first_e < 0) first_e = k;
      end
    end
    check("busy_start_count", n_done, 1, 0);
    check("busy_start_edge", first_e, 10, 0);
    check("busy_start_res", bus3.solution, 32'h3E800000, 2);

    // reset during MUL1 of the second iteration
    repeat (25) @(posedge clk);
    @(negedge clk); start = 1'b1; divide = 1'b0; op2 = 32'h40400000;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_busy", 32'(bus3.busy), 0, 0);
    check("abort_done", 32'(bus3.done), 0, 0);
    check("abort_solution", bus3.solution, 32'h0, 0);
    n_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus3.done) n_done++;
    end
    check("abort_no_done", n_done, 0, 0);
    do_vec("after_abort", 0, 1'b0, 32'h0, 32'h40000000, 32'h3F000000, 10, 2);

    // iteration-count sweep: one step is coarse, seven steps is accurate
    do_vec("it1_recip_3", 1, 1'b0, 32'h0, 32'h40400000, 32'h3EAAAAAB, 4, 40000);
    do_vec("it7_recip_3", 2, 1'b0, 32'h0, 32'h40400000, 32'h3EAAAAAB, 22, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
